// File: rtl/dac121s101_arbiter.sv
// Round-robin arbiter that shares one DAC121S101 SPI serializer among N_REQ
// requesters and sequences issue, SPI completion, settling and done pulse.
module dac121s101_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned SETTLE_CYCLES = 100,
  parameter int unsigned ID_W          = $clog2(N_REQ)
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     req_done,
  output logic                 spi_valid,
  output logic [15:0]          spi_data,
  input  logic                 spi_ready,
  input  logic                 spi_busy,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic [13:0]          last_frame
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_SPI = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    win_id;
  logic               win_found;
  logic [13:0]        win_frame;
  logic [ID_W-1:0]    cand;
  logic               take;
  logic               done_d;
  logic [N_REQ-1:0]   req_done_d;

  // Round-robin search starting one past the last winner, with wrap-around
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    win_frame = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = ID_W'((32'(ptr_q) + k) % N_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_id == ID_W'(i)) win_frame = req_data[16*i +: 14];
    end
  end

  // One-hot accept toward the winner, only while idle
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && win_found) req_ready[win_id] = 1'b1;
  end

  assign take = (state_q == IDLE) && win_found;

  // Next-state logic and settle counter
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    req_done_d = '0;
    case (state_q)
      IDLE: begin
        if (take) state_d = ISSUE;
      end
      ISSUE: begin
        if (spi_ready) state_d = WAIT_SPI;
      end
      WAIT_SPI: begin
        if (!spi_busy) begin
          if (SETTLE_CYCLES == 0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
          end
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (done_d) req_done_d[grant_id] = 1'b1;
  end

  // State, grant bookkeeping and registered outputs
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= ID_W'(N_REQ - 1);
      grant_id   <= '0;
      spi_valid  <= 1'b0;
      spi_data   <= '0;
      last_frame <= '0;
      req_done   <= '0;
      busy       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy      <= (state_d != IDLE);
      spi_valid <= (state_d == ISSUE);
      req_done  <= req_done_d;
      if (take) begin
        ptr_q    <= win_id;
        grant_id <= win_id;
        spi_data <= {2'b00, win_frame};
      end
      if (state_q == ISSUE && spi_ready) last_frame <= spi_data[13:0];
    end
  end

endmodule

// File: tb/tb_dac121s101_arbiter.sv
// Scoreboard bench for dac121s101_arbiter: a settling build (S=4, 4 requesters)
// and a zero-settle build (2 requesters), each with a simple serializer model.
module tb_dac121s101_arbiter;

  localparam int unsigned N       = 4;
  localparam int unsigned S       = 4;
  localparam int unsigned SPI_LEN = 16;
  localparam int unsigned ZN      = 2;
  localparam int unsigned ZLEN    = 3;

  typedef struct { logic [15:0] data; logic [2:0] id; } frm_t;
  typedef struct { string name; logic [31:0] act; logic [31:0] exp; } chk_t;

  logic ACLK = 1'b0;
  always #5 ACLK = ~ACLK;
  logic ARESETN;

  logic [N-1:0]    req_valid, req_ready, req_done, hold;
  logic [16*N-1:0] req_data;
  logic            spi_valid, spi_ready, spi_busy, busy;
  logic [15:0]     spi_data;
  logic [1:0]      grant_id;
  logic [13:0]     last_frame;

  logic [ZN-1:0]    z_valid, z_ready, z_done, zhold;
  logic [16*ZN-1:0] z_data;
  logic             z_spi_valid, z_spi_ready, z_spi_busy, z_busy;
  logic [15:0]      z_spi_data;
  logic [0:0]       z_grant;
  logic [13:0]      z_last;

  dac121s101_arbiter #(.N_REQ(N), .SETTLE_CYCLES(S)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .spi_valid(spi_valid),
    .spi_data(spi_data), .spi_ready(spi_ready), .spi_busy(spi_busy), .busy(busy),
    .grant_id(grant_id), .last_frame(last_frame));

  dac121s101_arbiter #(.N_REQ(ZN), .SETTLE_CYCLES(0)) dut_z (
    .ACLK(ACLK), .ARESETN(ARESETN), .req_valid(z_valid), .req_data(z_data),
    .req_ready(z_ready), .req_done(z_done), .spi_valid(z_spi_valid),
    .spi_data(z_spi_data), .spi_ready(z_spi_ready), .spi_busy(z_spi_busy), .busy(z_busy),
    .grant_id(z_grant), .last_frame(z_last));

  // Serializer models: busy for a fixed frame length after each accept
  int bcnt = 0, zbcnt = 0;
  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bcnt  <= 0;
      zbcnt <= 0;
    end else begin
      if (spi_valid && spi_ready) bcnt <= int'(SPI_LEN);
      else if (bcnt != 0)         bcnt <= bcnt - 1;
      if (z_spi_valid && z_spi_ready) zbcnt <= int'(ZLEN);
      else if (zbcnt != 0)            zbcnt <= zbcnt - 1;
    end
  end
  assign spi_busy   = (bcnt != 0);
  assign z_spi_busy = (zbcnt != 0);

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  frm_t frm_q[$], zfrm_q[$];
  int   done_q[$], zdone_q[$];
  chk_t chk_q[$];

  int n_checks = 0, n_fail = 0;
  int inflight = 0, fall_cyc = 0, zfall_cyc = 0;
  int hs_cnt = 0, zhs_cnt = 0, done_cnt = 0, zdone_cnt = 0;
  logic prev_busy = 1'b0, zprev_busy = 1'b0;

  task automatic compare(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUTs present a frame or a done pulse
  always @(negedge ACLK) begin
    chk_t c;
    frm_t f;
    int   id;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      compare(c.name, c.act, c.exp);
    end
    if (!ARESETN) begin
      inflight   = 0;
      prev_busy  = 1'b0;
      zprev_busy = 1'b0;
    end else begin
      if (prev_busy && !spi_busy) fall_cyc = cyc;
      prev_busy = spi_busy;
      if (zprev_busy && !z_spi_busy) zfall_cyc = cyc;
      zprev_busy = z_spi_busy;
      if (busy) compare("ready_while_busy", 32'(req_ready), 32'(0));
      if (spi_valid && spi_ready) begin
        compare("done_before_next", 32'(inflight), 32'(0));
        compare("frame_queued", 32'(frm_q.size() > 0), 32'(1));
        if (frm_q.size() > 0) begin
          f = frm_q.pop_front();
          compare("spi_data", 32'(spi_data), 32'(f.data));
          compare("grant_id", 32'(grant_id), 32'(f.id));
        end
        inflight = 1;
        hs_cnt++;
      end
      if (req_done != 0) begin
        compare("done_queued", 32'(done_q.size() > 0), 32'(1));
        if (done_q.size() > 0) begin
          id = done_q.pop_front();
          compare("req_done", 32'(req_done), 32'(1) << id);
          compare("done_latency", 32'(cyc - fall_cyc), 32'(S + 1));
        end
        inflight = 0;
        done_cnt++;
      end
      if (z_spi_valid && z_spi_ready) begin
        compare("z_frame_queued", 32'(zfrm_q.size() > 0), 32'(1));
        if (zfrm_q.size() > 0) begin
          f = zfrm_q.pop_front();
          compare("z_spi_data", 32'(z_spi_data), 32'(f.data));
          compare("z_grant_id", 32'(z_grant), 32'(f.id));
        end
        zhs_cnt++;
      end
      if (z_done != 0) begin
        compare("z_done_queued", 32'(zdone_q.size() > 0), 32'(1));
        if (zdone_q.size() > 0) begin
          id = zdone_q.pop_front();
          compare("z_req_done", 32'(z_done), 32'(1) << id);
          compare("z_done_latency", 32'(cyc - zfall_cyc), 32'(1));
        end
        if (zdone_cnt < 3) compare("z_accept_on_done", 32'(z_ready), 32'(1));
        zdone_cnt++;
      end
    end
  end

  task automatic expect_now(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = nm;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic push_frame(input logic [15:0] d, input int id);
    frm_t f;
    f.data = d;
    f.id   = 3'(id);
    frm_q.push_back(f);
  endtask

  // One clock: requesters drop valid after a transfer unless held
  task automatic tick();
    logic [N-1:0]  x;
    logic [ZN-1:0] zx;
    @(negedge ACLK);
    x  = req_valid & req_ready & ~hold;
    zx = z_valid & z_ready & ~zhold;
    @(posedge ACLK);
    #1;
    req_valid = req_valid & ~x;
    z_valid   = z_valid & ~zx;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (n < limit && !(frm_q.size() == 0 && done_q.size() == 0 && !busy && req_valid == 0)) begin
      tick();
      n++;
    end
    expect_now("idle_reached", 32'(n < limit), 32'(1));
  endtask

  task automatic wait_hs(input int target, input int limit);
    int n = 0;
    while (n < limit && hs_cnt < target) begin
      tick();
      n++;
    end
    expect_now("handshakes_reached", 32'(hs_cnt >= target), 32'(1));
  endtask

  initial begin
    int n;
    int base;
    frm_t zf;
    hold = '0; zhold = '0;
    req_valid = '0; req_data = '0;
    z_valid = '0; z_data = '0;
    spi_ready = 1'b1; z_spi_ready = 1'b1;
    ARESETN = 1'b1;
    #1 ARESETN = 1'b0;
    #1;
    expect_now("rst_spi_valid", 32'(spi_valid), 32'(0));
    expect_now("rst_spi_data", 32'(spi_data), 32'(0));
    expect_now("rst_busy", 32'(busy), 32'(0));
    expect_now("rst_grant_id", 32'(grant_id), 32'(0));
    expect_now("rst_last_frame", 32'(last_frame), 32'(0));
    expect_now("rst_req_done", 32'(req_done), 32'(0));
    expect_now("rst_req_ready", 32'(req_ready), 32'(0));
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESETN = 1'b1;

    // All four requesters after reset: grants 0,1,2,3
    req_data  = {16'h3444, 16'h2333, 16'h1222, 16'h0111};
    req_valid = 4'hF;
    push_frame(16'h0111, 0); push_frame(16'h1222, 1);
    push_frame(16'h2333, 2); push_frame(16'h3444, 3);
    done_q.push_back(0); done_q.push_back(1); done_q.push_back(2); done_q.push_back(3);
    wait_idle(400);

    // Single request from requester 2
    req_data[47:32] = 16'h3ABC;
    req_valid = 4'b0100;
    push_frame(16'h3ABC, 2);
    done_q.push_back(2);
    tick();
    expect_now("spi_valid_t1", 32'(spi_valid), 32'(1));
    expect_now("spi_data_t1", 32'(spi_data), 32'(16'h3ABC));
    expect_now("busy_t1", 32'(busy), 32'(1));
    wait_idle(200);
    expect_now("last_frame_a", 32'(last_frame), 32'(14'h3ABC));
    expect_now("grant_id_a", 32'(grant_id), 32'(2));

    // After grant 2, pending 1 and 3: 3 wins first
    req_data[31:16] = 16'h0011;
    req_data[63:48] = 16'h0033;
    req_valid = 4'b1010;
    push_frame(16'h0033, 3); push_frame(16'h0011, 1);
    done_q.push_back(3); done_q.push_back(1);
    wait_idle(300);

    // 0 and 1 held continuously: grants alternate 0,1,0,1
    req_data[15:0]  = 16'h0A00;
    req_data[31:16] = 16'h0B01;
    hold = 4'b0011;
    req_valid = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      push_frame((i % 2 == 0) ? 16'h0A00 : 16'h0B01, i % 2);
      done_q.push_back(i % 2);
    end
    base = hs_cnt;
    wait_hs(base + 4, 400);
    req_valid = '0;
    hold = '0;
    wait_idle(200);

    // Backpressure with masked top bits; requester 2 arrives while busy
    spi_ready = 1'b0;
    req_data[15:0] = 16'hFFFF;
    req_valid = 4'b0001;
    push_frame(16'h3FFF, 0);
    done_q.push_back(0);
    tick();
    req_data[47:32] = 16'h1234;
    req_valid = 4'b0100;
    push_frame(16'h1234, 2);
    done_q.push_back(2);
    for (int i = 0; i < 20; i++) begin
      expect_now("bp_hold", 32'({busy, spi_valid, req_ready, spi_data}),
                 32'({1'b1, 1'b1, 4'b0000, 16'h3FFF}));
      tick();
    end
    spi_ready = 1'b1;
    wait_idle(300);

    // Reset during SETTLE: no done for the aborted grant, ptr restarts
    req_data[31:16] = 16'h0555;
    req_valid = 4'b0010;
    push_frame(16'h0555, 1);
    tick();
    tick();
    n = 0;
    while (spi_busy && n < 40) begin
      tick();
      n++;
    end
    expect_now("spi_busy_fell", 32'(n < 40), 32'(1));
    tick();
    tick();
    req_data[31:16] = 16'h0777;
    req_data[47:32] = 16'h0666;
    req_valid = 4'b0110;
    push_frame(16'h0777, 1); push_frame(16'h0666, 2);
    done_q.push_back(1); done_q.push_back(2);
    #2 ARESETN = 1'b0;
    #1;
    expect_now("arst_spi_valid", 32'(spi_valid), 32'(0));
    expect_now("arst_spi_data", 32'(spi_data), 32'(0));
    expect_now("arst_busy", 32'(busy), 32'(0));
    expect_now("arst_grant_id", 32'(grant_id), 32'(0));
    expect_now("arst_last_frame", 32'(last_frame), 32'(0));
    expect_now("arst_req_done", 32'(req_done), 32'(0));
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESETN = 1'b1;
    wait_idle(300);
    expect_now("grant_id_after_rst", 32'(grant_id), 32'(2));
    expect_now("last_frame_after_rst", 32'(last_frame), 32'(14'h0666));

    // Zero-settle build: back-to-back grants to requester 0
    z_data = {16'h0000, 16'h0123};
    zhold = 2'b01;
    z_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      zf.data = 16'h0123;
      zf.id   = 3'd0;
      zfrm_q.push_back(zf);
      zdone_q.push_back(0);
    end
    n = 0;
    while (zhs_cnt < 4 && n < 200) begin
      tick();
      n++;
    end
    expect_now("z_handshakes", 32'(zhs_cnt), 32'(4));
    z_valid = '0;
    zhold = '0;
    n = 0;
    while (zdone_cnt < 4 && n < 100) begin
      tick();
      n++;
    end
    expect_now("z_dones", 32'(zdone_cnt), 32'(4));
    expect_now("frames_left", 32'(frm_q.size() + zfrm_q.size()), 32'(0));
    expect_now("dones_left", 32'(done_q.size() + zdone_q.size()), 32'(0));
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
